// File: rtl/pll_lock_detect.sv
// Lock detector for the Canary PLL: measures feedback-edge count and phase error per refclk
// window and walks lock_state UNLOCKED -> FREQ_LOCKED -> PHASE_LOCKED with hysteresis.
module pll_lock_detect #(
  parameter int unsigned WINDOW       = 64,
  parameter int unsigned FREQ_TOL     = 1,
  parameter int unsigned PHASE_W      = 8,
  parameter int unsigned PHASE_TOL    = 4,
  parameter int unsigned FREQ_GOOD_N  = 4,
  parameter int unsigned PHASE_GOOD_N = 8,
  localparam int unsigned CW          = $clog2(2 * WINDOW + 1)
) (
  input  logic                      refclk,
  input  logic                      reset,
  input  logic                      brake,
  input  logic                      fb_edge,
  input  logic                      phase_vld,
  input  logic signed [PHASE_W-1:0] phase_err,
  output logic [1:0]                lock_state,
  output logic                      lock_lost,
  output logic [CW-1:0]             fb_count
);

  localparam int unsigned WW  = $clog2(WINDOW);
  localparam int unsigned FGW = $clog2(FREQ_GOOD_N + 1);
  localparam int unsigned PGW = $clog2(PHASE_GOOD_N + 1);

  typedef enum logic [1:0] {
    StUnlocked    = 2'd0,
    StFreqLocked  = 2'd1,
    StPhaseLocked = 2'd2
  } lock_state_t;

  lock_state_t    state_q;
  logic [WW-1:0]  win_q;
  logic [CW-1:0]  edge_q;
  logic           vld_seen_q;
  logic           err_bad_q;
  logic [FGW-1:0] fg_q;
  logic [PGW-1:0] pg_q;

  logic           win_close;
  logic [CW-1:0]  edge_total;
  logic [CW:0]    freq_diff;
  logic           freq_good;
  logic [PHASE_W:0] err_ext;
  logic [PHASE_W:0] err_abs;
  logic           err_ok;
  logic           vld_seen_now;
  logic           err_bad_now;
  logic           phase_good;
  logic [FGW-1:0] fg_inc;
  logic [PGW-1:0] pg_inc;

  always_comb begin
    win_close  = (win_q == WW'(WINDOW - 1));
    // An edge in the closing cycle still belongs to the window being closed.
    edge_total = (fb_edge && (edge_q != CW'(2 * WINDOW))) ? edge_q + 1'b1 : edge_q;
    if ({1'b0, edge_total} >= (CW + 1)'(WINDOW)) begin
      freq_diff = {1'b0, edge_total} - (CW + 1)'(WINDOW);
    end else begin
      freq_diff = (CW + 1)'(WINDOW) - {1'b0, edge_total};
    end
    freq_good = (freq_diff <= (CW + 1)'(FREQ_TOL));

    // One extra bit so the most-negative error cannot wrap to a small magnitude.
    err_ext      = {phase_err[PHASE_W-1], phase_err};
    err_abs      = err_ext[PHASE_W] ? (~err_ext + 1'b1) : err_ext;
    err_ok       = (err_abs <= (PHASE_W + 1)'(PHASE_TOL));
    vld_seen_now = vld_seen_q | phase_vld;
    err_bad_now  = err_bad_q | (phase_vld & ~err_ok);
    phase_good   = vld_seen_now & ~err_bad_now;

    fg_inc = (fg_q >= FGW'(FREQ_GOOD_N))  ? FGW'(FREQ_GOOD_N)  : fg_q + 1'b1;
    pg_inc = (pg_q >= PGW'(PHASE_GOOD_N)) ? PGW'(PHASE_GOOD_N) : pg_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q    <= StUnlocked;
      lock_lost  <= 1'b0;
      fb_count   <= '0;
      win_q      <= '0;
      edge_q     <= '0;
      vld_seen_q <= 1'b0;
      err_bad_q  <= 1'b0;
      fg_q       <= '0;
      pg_q       <= '0;
    end else if (brake) begin
      state_q    <= StUnlocked;
      lock_lost  <= (state_q == StPhaseLocked);
      win_q      <= '0;
      edge_q     <= '0;
      vld_seen_q <= 1'b0;
      err_bad_q  <= 1'b0;
      fg_q       <= '0;
      pg_q       <= '0;
    end else if (win_close) begin
      lock_lost  <= 1'b0;
      fb_count   <= edge_total;
      win_q      <= '0;
      edge_q     <= '0;
      vld_seen_q <= 1'b0;
      err_bad_q  <= 1'b0;
      if (!freq_good) begin
        state_q   <= StUnlocked;
        lock_lost <= (state_q == StPhaseLocked);
        fg_q      <= '0;
        pg_q      <= '0;
      end else begin
        fg_q <= fg_inc;
        if (!phase_good) pg_q <= '0;
        unique case (state_q)
          StUnlocked: begin
            if (fg_inc >= FGW'(FREQ_GOOD_N)) state_q <= StFreqLocked;
          end
          StFreqLocked: begin
            if (phase_good) begin
              pg_q <= pg_inc;
              if (pg_inc >= PGW'(PHASE_GOOD_N)) state_q <= StPhaseLocked;
            end
          end
          StPhaseLocked: begin
            if (!phase_good) begin
              state_q   <= StFreqLocked;
              lock_lost <= 1'b1;
            end
          end
          default: state_q <= StUnlocked;
        endcase
      end
    end else begin
      lock_lost  <= 1'b0;
      win_q      <= win_q + 1'b1;
      edge_q     <= edge_total;
      vld_seen_q <= vld_seen_now;
      err_bad_q  <= err_bad_now;
      if (!(state_q inside {StUnlocked, StFreqLocked, StPhaseLocked})) state_q <= StUnlocked;
    end
  end

  assign lock_state = state_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: directed lock/unlock scenarios plus randomized traffic, every cycle
// compared against a window-accounting reference model.
module tb_pll_lock_detect;

  localparam int W  = 64;
  localparam int FT = 1;
  localparam int PT = 4;
  localparam int FN = 4;
  localparam int PN = 8;

  logic              refclk = 1'b0;
  logic              reset = 1'b1;
  logic              brake = 1'b0;
  logic              fb_edge = 1'b0;
  logic              phase_vld = 1'b0;
  logic signed [7:0] phase_err = '0;
  logic [1:0]        lock_state;
  logic              lock_lost;
  logic [7:0]        fb_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer bookkeeping of the current window and lock progress.
  int m_state = 0, m_lost = 0, m_fbcount = 0;
  int m_win = 0, m_edges = 0, m_seen = 0, m_bad = 0, m_fg = 0, m_pg = 0;

  pll_lock_detect dut (
    .refclk     (refclk),
    .reset      (reset),
    .brake      (brake),
    .fb_edge    (fb_edge),
    .phase_vld  (phase_vld),
    .phase_err  (phase_err),
    .lock_state (lock_state),
    .lock_lost  (lock_lost),
    .fb_count   (fb_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int fb, input int v, input int e, input int brk, input int rst);
    int prev, mag;
    if (rst != 0) begin
      m_state = 0; m_lost = 0; m_fbcount = 0;
      m_win = 0; m_edges = 0; m_seen = 0; m_bad = 0; m_fg = 0; m_pg = 0;
    end else if (brk != 0) begin
      m_lost = (m_state == 2) ? 1 : 0;
      m_state = 0;
      m_win = 0; m_edges = 0; m_seen = 0; m_bad = 0; m_fg = 0; m_pg = 0;
    end else begin
      m_lost = 0;
      m_edges = (m_edges + fb > 2 * W) ? 2 * W : m_edges + fb;
      if (v != 0) begin
        mag = (e < 0) ? -e : e;
        m_seen = 1;
        if (mag > PT) m_bad = 1;
      end
      if (m_win == W - 1) begin
        prev = m_state;
        m_fbcount = m_edges;
        if (((m_edges > W) ? m_edges - W : W - m_edges) > FT) begin
          m_fg = 0; m_pg = 0; m_state = 0;
        end else begin
          m_fg = (m_fg + 1 > FN) ? FN : m_fg + 1;
          if (m_seen == 0 || m_bad != 0) begin
            m_pg = 0;
            if (prev == 2) m_state = 1;
          end else if (prev == 1) begin
            m_pg = (m_pg + 1 > PN) ? PN : m_pg + 1;
          end
          if (prev == 0 && m_fg >= FN) m_state = 1;
          if (prev == 1 && m_pg >= PN) m_state = 2;
        end
        m_lost = (prev == 2 && m_state != 2) ? 1 : 0;
        m_win = 0; m_edges = 0; m_seen = 0; m_bad = 0;
      end else begin
        m_win++;
      end
    end
  endtask

  // Apply one cycle of inputs, then compare every output against the model.
  task automatic step(input int fb, input int v, input int e, input int brk, input int rst);
    logic [31:0] ev;
    ev = e;
    fb_edge   = fb[0];
    phase_vld = v[0];
    phase_err = ev[7:0];
    brake     = brk[0];
    reset     = rst[0];
    @(posedge refclk);
    model_update(fb, v, e, brk, rst);
    #1;
    check("lock_state", 32'(lock_state), 32'(m_state));
    check("lock_lost", 32'(lock_lost), 32'(m_lost));
    check("fb_count", 32'(fb_count), 32'(m_fbcount));
  endtask

  // One aligned window: 'drop' consecutive missing edges at a random spot; optional phase samples
  // with random good errors, and optionally one injected error value.
  task automatic run_window(input int drop, input int vld, input int inject, input int bad_val);
    int r, bi, e;
    r  = int'($urandom_range(0, W - drop));
    bi = int'($urandom_range(0, W - 1));
    for (int i = 0; i < W; i++) begin
      e = int'($urandom_range(0, 2 * PT)) - PT;
      if (inject != 0 && i == bi) e = bad_val;
      step((i >= r && i < r + drop) ? 0 : 1, vld, e, 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    check("reset_state", 32'(lock_state), 32'd0);

    // Edges only, no phase samples: freq lock after 4 windows, never phase lock.
    for (int i = 0; i < 3; i++) run_window(0, 0, 0, 0);
    check("no_lock_w3", 32'(lock_state), 32'd0);
    run_window(0, 0, 0, 0);
    check("freq_lock_w4", 32'(lock_state), 32'd1);
    check("fb_count_64", 32'(fb_count), 32'd64);
    for (int i = 0; i < 8; i++) run_window(0, 0, 0, 0);
    check("no_phase_wo_vld", 32'(lock_state), 32'd1);

    // Fresh start with good phase every cycle: FREQ at window 4, PHASE at window 12.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) run_window(0, 1, 1, 3);
    check("freq_not_phase_w11", 32'(lock_state), 32'd1);
    run_window(0, 1, 1, 3);
    check("phase_lock_w12", 32'(lock_state), 32'd2);

    // Boundary errors +4/-4 remain good; a single -5 drops to FREQ_LOCKED.
    run_window(0, 1, 1, 4);
    run_window(0, 1, 1, -4);
    check("tol_edge_kept", 32'(lock_state), 32'd2);
    run_window(0, 1, 1, -5);
    check("phase_bad_drop", 32'(lock_state), 32'd1);
    check("lock_lost_pulse", 32'(lock_lost), 32'd1);
    step(1, 1, 0, 0, 0);
    for (int i = 1; i < W; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) run_window(0, 1, 0, 0);
    check("relock_phase", 32'(lock_state), 32'd2);

    // 63 edges is within tolerance; 62 edges unlocks.
    run_window(1, 1, 0, 0);
    check("edges63_locked", 32'(lock_state), 32'd2);
    run_window(2, 1, 0, 0);
    check("edges62_unlock", 32'(lock_state), 32'd0);
    check("edges62_count", 32'(fb_count), 32'd62);
    for (int i = 0; i < 12; i++) run_window(0, 1, 0, 0);
    check("relock_after_freq", 32'(lock_state), 32'd2);

    // Most-negative error is phase-bad.
    run_window(0, 1, 1, -128);
    check("err_min_bad", 32'(lock_state), 32'd1);
    for (int i = 0; i < 8; i++) run_window(0, 1, 0, 0);

    // One-cycle brake mid-window from PHASE_LOCKED; relock needs the full 4+8 windows again.
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    check("brake_unlock", 32'(lock_state), 32'd0);
    check("brake_lost", 32'(lock_lost), 32'd1);
    for (int i = 0; i < 11; i++) run_window(0, 1, 0, 0);
    check("brake_relock_w11", 32'(lock_state), 32'd1);
    run_window(0, 1, 0, 0);
    check("brake_relock_w12", 32'(lock_state), 32'd2);

    // Held brake across a window close.
    for (int i = 0; i < W + 10; i++) step(1, 1, 0, 1, 0);
    check("brake_held", 32'(lock_state), 32'd0);

    // Randomized traffic, not window-aligned.
    for (int i = 0; i < 40 * W; i++) begin
      step(($urandom_range(0, 99) < 99) ? 1 : 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 12)) - 6, ($urandom_range(0, 999) == 0) ? 1 : 0, 0);
    end

    // Reset mid-window after reaching lock.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) run_window(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    check("reset_mid_state", 32'(lock_state), 32'd0);
    check("reset_mid_count", 32'(fb_count), 32'd0);
    for (int i = 0; i < 4; i++) run_window(0, 0, 0, 0);
    check("reset_mid_relock", 32'(lock_state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
